// File: rtl/div.sv
// ============================================================================
// div : 32-bit signed restoring divider, one quotient bit per clock.
// Optional DIV_ZERO_EXCEPTION_EN: trap b == 0 at start with a 1-cycle done.
// Revision: 1.0
// ============================================================================
`default_nettype none

module div #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] low,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] rem_q,   rem_d;
  logic [WIDTH-1:0] quo_q,   quo_d;
  logic [WIDTH-1:0] dvs_q,   dvs_d;
  logic             sa_q,    sa_d;
  logic             sb_q,    sb_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic [WIDTH-1:0] hi_q,    hi_d;
  logic [WIDTH-1:0] low_q,   low_d;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             zero_trap;

  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;

  // The stored remainder is always below the divisor, so 32 bits suffice;
  // only the shifted trial value needs the extra bit.
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dvs_q};

`ifdef DIV_ZERO_EXCEPTION_EN
  logic dz_q, dz_d;

  assign zero_trap = (b == '0);
  assign dz_d      = (state_q == S_IDLE) && start && zero_trap;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dz_q <= 1'b0;
    end else begin
      dz_q <= dz_d;
    end
  end

  assign div_zero = dz_q;
`else
  assign zero_trap = 1'b0;
  assign div_zero  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    low_d   = low_q;

    case (state_q)
      S_IDLE: begin
        if (start && zero_trap) begin
          done_d = 1'b1;
          hi_d   = '0;
          low_d  = '0;
        end else if (start) begin
          state_d = S_RUN;
          busy_d  = 1'b1;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = a_mag;
          dvs_d   = b_mag;
          sa_d    = a[WIDTH-1];
          sb_d    = b[WIDTH-1];
        end
      end

      S_RUN: begin
        // Dividend bits shift out of quo_q as quotient bits shift in.
        quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
        rem_d = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        low_d   = (sa_q ^ sb_q) ? -quo_q : quo_q;
        hi_d    = sa_q ? -rem_q : rem_q;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      low_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      low_q   <= low_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign low  = low_q;

endmodule

`default_nettype wire

// File: tb/tb_div.sv
// ============================================================================
// tb_div : directed + randomized checks of div against an arithmetic model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_div;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] low;
  logic        div_zero;

  int passed = 0;
  int total  = 0;

  logic [31:0] hold_hi;
  logic [31:0] hold_low;
  int          changed;

  div #(.WIDTH(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .low      (low),
    .div_zero (div_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", passed, total);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: signed quotient truncated toward zero, remainder takes the
  // dividend's sign; wide arithmetic makes the 0x80000000 / -1 case wrap.
  function automatic void model(input logic [31:0] ta, input logic [31:0] tb_,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic dz, output int lat);
    longint la, lb, q64, r64;
    la = longint'($signed(ta));
    lb = longint'($signed(tb_));
    if (lb == 0) begin
`ifdef DIV_ZERO_EXCEPTION_EN
      q = 32'h0; r = 32'h0; dz = 1'b1; lat = 1;
`else
      q = (la >= 0) ? 32'hFFFF_FFFF : 32'h0000_0001;
      r = ta; dz = 1'b0; lat = 34;
`endif
    end else begin
      q64 = la / lb;
      r64 = la - q64 * lb;
      q = q64[31:0]; r = r64[31:0]; dz = 1'b0; lat = 34;
    end
  endfunction

  task automatic launch(input logic [31:0] ta, input logic [31:0] tb_);
    start = 1'b1;
    a     = ta;
    b     = tb_;
  endtask

  // Counts edges from the accepting edge up to the edge that raises done.
  task automatic wait_done(input bit garbage, output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    do begin
      @(posedge clock);
      lat++;
      #1;
      if (lat == 1) begin
        start = 1'b0;
        a = $urandom;
        b = $urandom;
      end
      if (garbage && lat == 10 && !done) begin
        start = 1'b1;
        a = $urandom;
        b = $urandom_range(1, 9);
      end
      if (garbage && lat == 11) start = 1'b0;
      if (busy) busy_cnt++;
      if (!done && (hi !== hold_hi || low !== hold_low)) changed++;
    end while (!done && lat < 200);
  endtask

  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                        input bit garbage);
    logic [31:0] eq, er;
    logic        edz;
    int          elat, lat, bc;
    model(ta, tb_, eq, er, edz, elat);
    hold_hi  = hi;
    hold_low = low;
    changed  = 0;
    launch(ta, tb_);
    wait_done(garbage, lat, bc);
    chk({tag, "_latency"}, lat, elat);
    chk({tag, "_busy_cycles"}, bc, elat - 1);
    chk({tag, "_low"}, low, eq);
    chk({tag, "_hi"}, hi, er);
    chk({tag, "_div_zero"}, div_zero, edz);
    chk({tag, "_busy_at_done"}, busy, 1'b0);
    chk({tag, "_hold"}, changed, 0);
  endtask

  task automatic done_drop(input string tag);
    logic [31:0] sh, sl;
    sh = hi;
    sl = low;
    @(posedge clock);
    #1;
    chk({tag, "_done_pulse"}, done, 1'b0);
    chk({tag, "_stable"}, {hi, low}, {sh, sl});
  endtask

  initial begin
    logic [31:0] ra, rb;
    int dcnt, bcnt;

    reset = 1'b1;
    start = 1'b0;
    a = 32'h0;
    b = 32'h0;
    #2;
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_hi", hi, 32'h0);
    chk("reset_low", low, 32'h0);
    chk("reset_div_zero", div_zero, 1'b0);

    // Start issued for the very first edge after reset releases.
    repeat (2) @(negedge clock);
    reset = 1'b0;
    run_op("p100_d7", 32'd100, 32'd7, 1'b1);
    chk("p100_d7_low_abs", low, 32'd14);
    chk("p100_d7_hi_abs", hi, 32'd2);
    done_drop("p100_d7");

    @(negedge clock);
    run_op("m100_d7", 32'hFFFF_FF9C, 32'd7, 1'b0);
    chk("m100_d7_low_abs", low, 32'hFFFF_FFF2);
    chk("m100_d7_hi_abs", hi, 32'hFFFF_FFFE);
    done_drop("m100_d7");

    @(negedge clock);
    run_op("p100_m7", 32'd100, 32'hFFFF_FFF9, 1'b0);
    chk("p100_m7_low_abs", low, 32'hFFFF_FFF2);
    chk("p100_m7_hi_abs", hi, 32'd2);
    done_drop("p100_m7");

    @(negedge clock);
    run_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    chk("ovf_low_abs", low, 32'h8000_0000);
    chk("ovf_hi_abs", hi, 32'h0);
    done_drop("ovf");

    @(negedge clock);
    run_op("p5_d0", 32'd5, 32'd0, 1'b0);
`ifndef DIV_ZERO_EXCEPTION_EN
    chk("p5_d0_low_abs", low, 32'hFFFF_FFFF);
    chk("p5_d0_hi_abs", hi, 32'd5);
`endif
    done_drop("p5_d0");

    @(negedge clock);
    run_op("m5_d0", 32'hFFFF_FFFB, 32'd0, 1'b0);
    done_drop("m5_d0");

    // Back-to-back: new start raised during the done cycle.
    @(negedge clock);
    run_op("b2b_first", 32'd100, 32'd7, 1'b0);
    run_op("b2b_second", 32'hFFFF_FFF7, 32'd2, 1'b0);
    chk("b2b_low_abs", low, 32'hFFFF_FFFC);
    chk("b2b_hi_abs", hi, 32'hFFFF_FFFF);
    done_drop("b2b");

    // Reset mid-run, with an ignored second start along the way.
    @(negedge clock);
    launch(32'd100, 32'd7);
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock);
      #1;
      if (i == 1) start = 1'b0;
      if (i == 10) launch(32'd9, 32'd3);
      if (i == 11) start = 1'b0;
    end
    reset = 1'b1;
    #1;
    chk("midrun_reset_busy", busy, 1'b0);
    chk("midrun_reset_done", done, 1'b0);
    chk("midrun_reset_hi", hi, 32'h0);
    chk("midrun_reset_low", low, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    dcnt = 0;
    bcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (done) dcnt++;
      if (busy) bcnt++;
    end
    chk("after_reset_no_done", dcnt, 0);
    chk("after_reset_no_busy", bcnt, 0);
    @(negedge clock);
    run_op("p9_d3", 32'd9, 32'd3, 1'b0);
    chk("p9_d3_low_abs", low, 32'd3);
    chk("p9_d3_hi_abs", hi, 32'd0);
    done_drop("p9_d3");

    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 3 == 0) rb = $urandom_range(1, 20);
      if (i % 4 == 1) rb = -$urandom_range(1, 300);
      if (i % 5 == 2) ra = $urandom_range(0, 50);
      if (i == 7) rb = 32'h0;
      @(negedge clock);
      run_op($sformatf("rand%0d", i), ra, rb, (i % 2) == 0);
      done_drop($sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL provide port clock  input  1  rising-edge clock for all state.
REQ-003 SHALL provide port reset  input  1  asynchronous active-high reset.
REQ-004 SHALL provide port start  input  1  request pulse, sampled only in IDLE.
REQ-005 SHALL provide port a  input  32  signed dividend, captured on accepted start.
REQ-006 SHALL provide port b  input  32  signed divisor, captured on accepted start.
REQ-007 SHALL provide port busy  output  1  high while a division is in progress.
REQ-008 SHALL provide port done  output  1  one-cycle pulse marking valid hi/low.
REQ-009 SHALL provide port hi  output  32  registered remainder.
REQ-010 SHALL provide port low  output  32  registered quotient.
REQ-011 SHALL provide port div_zero  output  1  divide-by-zero flag (see Configuration).

Function
REQ-012 SHALL implement states IDLE, RUN, FIX; IDLE->RUN on start, RUN->FIX after 32 iterations, FIX->IDLE unconditionally.
REQ-013 SHALL, on accepting start in IDLE, capture |a|, |b|, sign(a), sign(b), clear partial remainder, load iteration counter 0.
REQ-014 SHALL perform one restoring shift-subtract step per RUN cycle on unsigned magnitudes (33-bit partial remainder), MSB of quotient first.
REQ-015 SHALL, in FIX, negate quotient if sign(a) xor sign(b), negate remainder if sign(a), and write results to low/hi.
REQ-016 SHALL produce quotient truncated toward zero; remainder carries sign of dividend; a = low*b + hi for all b != 0.
REQ-017 SHALL assert done for exactly one cycle, on the cycle after the 34th rising edge counted from the edge that sampled start (inclusive).
REQ-018 SHALL hold busy high from the edge after accepted start until the edge that asserts done; busy low when done is high.
REQ-019 SHALL ignore start while busy; captured operands unaffected.
REQ-020 SHALL accept a new start in the same cycle done is high (back-to-back).
REQ-021 SHALL hold hi/low stable between done pulses; a and b may change freely after capture.
REQ-022 SHALL yield low = 0x80000000, hi = 0 for a = 0x80000000, b = 0xFFFFFFFF (overflow wraps, no flag).

Reset
REQ-023 SHALL, on reset high (any time, including mid-RUN), enter IDLE asynchronously and force busy, done, div_zero to 0 and hi, low to 0x00000000.
REQ-024 SHALL accept start on the first rising edge after reset deasserts.

Configuration
REQ-025 SHALL honour macro DIV_ZERO_EXCEPTION_EN.
REQ-026 SHALL, with DIV_ZERO_EXCEPTION_EN defined, detect b == 0 at start acceptance, skip RUN/FIX, and on the next edge assert done and div_zero together for one cycle with hi = 0, low = 0.
REQ-027 SHALL, without DIV_ZERO_EXCEPTION_EN, tie div_zero to 0 and run b == 0 through the normal 34-edge path, giving hi = a, low = 0xFFFFFFFF if a >= 0 else 0x00000001.

Verification
REQ-028 SHALL cover: a=100, b=7, start -> done after 34 edges, low=14, hi=2, busy high 33 cycles.
REQ-029 SHALL cover: a=-100, b=7 -> low=0xFFFFFFF2, hi=0xFFFFFFFE; a=100, b=-7 -> low=0xFFFFFFF2, hi=2.
REQ-030 SHALL cover: a=0x80000000, b=0xFFFFFFFF -> low=0x80000000, hi=0, div_zero=0.
REQ-031 SHALL cover: a=5, b=0 -> with macro done+div_zero one edge after start, hi=low=0; without macro done after 34 edges, low=0xFFFFFFFF, hi=5.
REQ-032 SHALL cover: start a=100,b=7; second start a=9,b=3 at iteration 10; reset pulse at iteration 20 -> second start ignored, no done, outputs 0, busy 0; next start a=9,b=3 -> low=3, hi=0.
REQ-033 SHALL cover: start asserted in the done cycle with a=-9, b=2 -> accepted, next done gives low=0xFFFFFFFC, hi=0xFFFFFFFF.
